// File: rtl/io_port_hub_pkg.sv
// Shared constants for io_port_hub: device map, register map and a W1C helper.
package io_port_hub_pkg;

  localparam int DEV_LED = 0;
  localparam int DEV_SW  = 1;
  localparam int DEV_BTN = 2;
  localparam int DEV_TMR = 3;

  localparam int REG_LED_VAL    = 0;
  localparam int REG_SW_VAL     = 0;
  localparam int REG_BTN_LEVEL  = 0;
  localparam int REG_BTN_PRESS  = 1;
  localparam int REG_TMR_EN     = 0;
  localparam int REG_TMR_PERIOD = 1;
  localparam int REG_TMR_COUNT  = 2;
  localparam int REG_TMR_WRAP   = 3;

  // Sticky flag with write-one-to-clear; a same-cycle set beats the clear.
  function automatic logic w1c_next(input logic cur, input logic set, input logic clr);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a counter debouncer for one raw input.
module io_debounce #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEB_CYCLES < 2) ? 1 : $clog2(DEB_CYCLES + 1);

  logic [1:0]       sync_reg;
  logic             level_reg, level_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             differ, expire;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync_reg  <= {sync_reg[0], din};
      level_reg <= level_next;
      cnt_reg   <= cnt_next;
    end
  end

  // The level flips on the DEB_CYCLES-th consecutive cycle of disagreement.
  always_comb begin
    differ     = (sync_reg[1] != level_reg);
    expire     = differ && (cnt_reg == CNT_W'(DEB_CYCLES - 1));
    level_next = level_reg;
    cnt_next   = cnt_reg;
    if (!differ) begin
      cnt_next = '0;
    end else if (expire) begin
      cnt_next   = '0;
      level_next = ~level_reg;
    end else begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  assign level = level_reg;
  assign rise  = expire & ~level_reg;

endmodule

// File: rtl/io_port_hub.sv
// Memory-mapped IO hub: LED register, synchronised switches, debounced button
// with press flag, and a free-running period timer with wrap flag.
module io_port_hub
  import io_port_hub_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int DEV_W      = 3,
  parameter int REG_W      = 2,
  parameter int N_LED      = 8,
  parameter int N_SW       = 8,
  parameter int DEB_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DEV_W-1:0]  dev_sel,
  input  logic [REG_W-1:0]  reg_sel,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  output logic [DATA_W-1:0] data_out,
  output logic [N_LED-1:0]  Led,
  input  logic [N_SW-1:0]   sw,
  input  logic              btnS
);

  logic [DATA_W-1:0] led_reg, led_next;
  logic [N_SW-1:0]   sw_sync;
  logic              btn_level, btn_rise;
  logic              press_reg, press_next;
  logic              tmr_en_reg, tmr_en_next;
  logic [DATA_W-1:0] period_reg, period_next;
  logic [DATA_W-1:0] count_reg, count_next;
  logic              wrap_reg, wrap_next;
  logic              wrap_set;
  logic              sel_led, sel_btn, sel_tmr;
  logic [DATA_W-1:0] rd_data;

  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_sw_sync
      logic meta_reg, sync_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= sw[gi];
          sync_reg <= meta_reg;
        end
      end
      assign sw_sync[gi] = sync_reg;
    end
  endgenerate

  io_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_deb (
    .clk  (clk),
    .rst  (rst),
    .din  (btnS),
    .level(btn_level),
    .rise (btn_rise)
  );

  assign sel_led = (dev_sel == DEV_W'(DEV_LED));
  assign sel_btn = (dev_sel == DEV_W'(DEV_BTN));
  assign sel_tmr = (dev_sel == DEV_W'(DEV_TMR));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_reg    <= '0;
      press_reg  <= 1'b0;
      tmr_en_reg <= 1'b0;
      period_reg <= '0;
      count_reg  <= '0;
      wrap_reg   <= 1'b0;
    end else begin
      led_reg    <= led_next;
      press_reg  <= press_next;
      tmr_en_reg <= tmr_en_next;
      period_reg <= period_next;
      count_reg  <= count_next;
      wrap_reg   <= wrap_next;
    end
  end

  // Timer advance uses the pre-write enable/period; writes land alongside.
  always_comb begin
    led_next    = led_reg;
    tmr_en_next = tmr_en_reg;
    period_next = period_reg;
    count_next  = count_reg;
    wrap_set    = tmr_en_reg && (count_reg >= period_reg);

    if (tmr_en_reg) begin
      count_next = wrap_set ? '0 : count_reg + 1'b1;
    end

    if (we && sel_led && reg_sel == REG_W'(REG_LED_VAL)) begin
      led_next = data_in;
    end
    if (we && sel_tmr && reg_sel == REG_W'(REG_TMR_EN)) begin
      tmr_en_next = data_in[0];
    end
    if (we && sel_tmr && reg_sel == REG_W'(REG_TMR_PERIOD)) begin
      period_next = data_in;
    end

    press_next = w1c_next(press_reg, btn_rise,
                          we && sel_btn && reg_sel == REG_W'(REG_BTN_PRESS) && data_in[0]);
    wrap_next  = w1c_next(wrap_reg, wrap_set,
                          we && sel_tmr && reg_sel == REG_W'(REG_TMR_WRAP) && data_in[0]);
  end

  always_comb begin
    rd_data = '0;
    if (sel_led) begin
      if (reg_sel == REG_W'(REG_LED_VAL)) rd_data = led_reg;
    end else if (dev_sel == DEV_W'(DEV_SW)) begin
      if (reg_sel == REG_W'(REG_SW_VAL)) rd_data = DATA_W'(sw_sync);
    end else if (sel_btn) begin
      if (reg_sel == REG_W'(REG_BTN_LEVEL)) rd_data = DATA_W'(btn_level);
      else if (reg_sel == REG_W'(REG_BTN_PRESS)) rd_data = DATA_W'(press_reg);
    end else if (sel_tmr) begin
      case (reg_sel)
        REG_W'(REG_TMR_EN):     rd_data = DATA_W'(tmr_en_reg);
        REG_W'(REG_TMR_PERIOD): rd_data = period_reg;
        REG_W'(REG_TMR_COUNT):  rd_data = count_reg;
        default:                rd_data = DATA_W'(wrap_reg);
      endcase
    end
  end

  assign data_out = rd_data;
  assign Led      = led_reg[N_LED-1:0];

endmodule

// File: tb/tb_io_port_hub.sv
// Scoreboard bench for io_port_hub: reads queue an expected value when driven
// and are checked when data_out settles; a small timer model tracks dev 3.
module tb_io_port_hub;

  localparam int DATA_W = 16;
  localparam int DEV_W  = 3;
  localparam int REG_W  = 2;
  localparam int N_LED  = 8;
  localparam int N_SW   = 8;
  localparam int DEB    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DEV_W-1:0]  dev_sel;
  logic [REG_W-1:0]  reg_sel;
  logic [DATA_W-1:0] data_in;
  logic              we;
  logic [DATA_W-1:0] data_out;
  logic [N_LED-1:0]  Led;
  logic [N_SW-1:0]   sw;
  logic              btnS;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DATA_W-1:0] exp_q[$];
  string             tag_q[$];

  logic              m_en, m_flag;
  logic [DATA_W-1:0] m_per, m_cnt;

  io_port_hub #(
    .DATA_W(DATA_W), .DEV_W(DEV_W), .REG_W(REG_W),
    .N_LED(N_LED), .N_SW(N_SW), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .dev_sel(dev_sel), .reg_sel(reg_sel),
    .data_in(data_in), .we(we), .data_out(data_out),
    .Led(Led), .sw(sw), .btnS(btnS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s got=%h", tag, got);
    end
  endtask

  task automatic rd(input int dev, input int rg, input logic [DATA_W-1:0] exp, input string tag);
    dev_sel = DEV_W'(dev);
    reg_sel = REG_W'(rg);
    we      = 1'b0;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    #1;
    chk(tag_q.pop_front(), data_out, exp_q.pop_front());
  endtask

  task automatic model_reset();
    m_en = 1'b0; m_flag = 1'b0; m_per = '0; m_cnt = '0;
  endtask

  // One clock: drive the bus, wait for the next falling edge, advance the model.
  task automatic tick(input int dev, input int rg, input logic [DATA_W-1:0] d, input logic w);
    logic wrap;
    dev_sel = DEV_W'(dev);
    reg_sel = REG_W'(rg);
    data_in = d;
    we      = w;
    @(negedge clk);
    we   = 1'b0;
    wrap = m_en && (m_cnt >= m_per);
    if (m_en) m_cnt = wrap ? '0 : m_cnt + 1'b1;
    m_flag = wrap | (m_flag & ~(w && dev == 3 && rg == 3 && d[0]));
    if (w && dev == 3 && rg == 0) m_en = d[0];
    if (w && dev == 3 && rg == 1) m_per = d;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0, 1'b0);
  endtask

  task automatic chk_tmr(input string tag);
    rd(3, 2, m_cnt, {tag, "_cnt"});
    rd(3, 3, {15'b0, m_flag}, {tag, "_flag"});
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_led"}, Led, 0);
    for (int dv = 0; dv < 8; dv++)
      for (int r = 0; r < 4; r++)
        if (dv != 1) rd(dv, r, '0, $sformatf("%s_d%0dr%0d", tag, dv, r));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    rst = 1'b1; dev_sel = '0; reg_sel = '0; data_in = '0; we = 1'b0;
    sw = '0; btnS = 1'b0;
    model_reset();
    #1;
    all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    rd(1, 0, '0, "sw_after_rst");

    tick(0, 0, 16'h00A5, 1'b1);
    chk("led_a5", Led, 8'hA5);
    rd(0, 0, 16'h00A5, "led_rd");
    tick(0, 1, 16'hFFFF, 1'b1);
    rd(0, 1, '0, "led_reg1");
    chk("led_keep", Led, 8'hA5);
    tick(5, 0, 16'h1234, 1'b1);
    rd(5, 0, '0, "dev5_rd");
    tick(1, 0, 16'hFFFF, 1'b1);
    rd(1, 0, '0, "sw_wr_ignored");

    sw = 8'h3C;
    rd(1, 0, '0, "sw_0cyc");
    idle(1);
    rd(1, 0, '0, "sw_1cyc");
    idle(1);
    rd(1, 0, 16'h003C, "sw_2cyc");

    btnS = 1'b1; idle(3); btnS = 1'b0; idle(8);
    rd(2, 0, '0, "glitch_level");
    rd(2, 1, '0, "glitch_flag");
    btnS = 1'b1; idle(10);
    rd(2, 0, 16'h1, "press_level");
    rd(2, 1, 16'h1, "press_flag");
    btnS = 1'b0; idle(10);
    rd(2, 0, '0, "release_level");
    rd(2, 1, 16'h1, "flag_sticky");
    tick(2, 1, 16'h1, 1'b1);
    rd(2, 1, '0, "flag_w1c");

    tick(3, 1, 16'd3, 1'b1);
    tick(3, 0, 16'd1, 1'b1);
    rd(3, 1, 16'd3, "tmr_period");
    for (int i = 0; i < 9; i++) begin
      chk_tmr($sformatf("seq%0d", i));
      idle(1);
    end
    guard = 0;
    while (m_cnt >= m_per && guard < 8) begin idle(1); guard++; end
    tick(3, 3, 16'h1, 1'b1);
    chk_tmr("w1c_plain");
    guard = 0;
    while (m_cnt != 3 && guard < 8) begin idle(1); guard++; end
    tick(3, 3, 16'h1, 1'b1);
    rd(3, 3, 16'h1, "wrap_collide");
    rd(3, 2, '0, "wrap_collide_cnt");

    tick(3, 1, 16'd10, 1'b1);
    guard = 0;
    while (m_cnt != 6 && guard < 16) begin chk_tmr("run10"); idle(1); guard++; end
    tick(3, 1, 16'd2, 1'b1);
    chk_tmr("lower_write");
    idle(1);
    rd(3, 2, '0, "lower_wrap");
    chk_tmr("lower_model");

    tick(3, 1, 16'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(3, 3, 16'h1, 1'b1);
      rd(3, 3, 16'h1, $sformatf("p0_flag%0d", i));
      rd(3, 2, '0, $sformatf("p0_cnt%0d", i));
    end

    tick(3, 1, 16'd5, 1'b1);
    idle(2);
    tick(3, 0, 16'd0, 1'b1);
    idle(3);
    rd(3, 2, 16'd3, "hold_disabled");
    chk_tmr("hold_model");

    tick(3, 0, 16'd1, 1'b1);
    idle(2);
    btnS = 1'b1;
    idle(2);
    rst = 1'b1;
    #1;
    model_reset();
    all_zero("mid_rst");
    rd(1, 0, '0, "mid_rst_sw");
    @(negedge clk);
    rst  = 1'b0;
    btnS = 1'b0;
    rd(1, 0, '0, "rel_sw0");
    idle(1);
    rd(1, 0, '0, "rel_sw1");
    idle(1);
    rd(1, 0, 16'h003C, "rel_sw2");
    idle(3);
    rd(3, 2, '0, "tmr_idle");
    rd(3, 0, '0, "tmr_en_off");
    rd(2, 0, '0, "btn_after_rst");
    chk("led_after_rst", Led, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
